// File: rtl/mat_operand_loader.sv
// Collects eight serial elements into a 2x2 operand pair (A then B)
// and holds the pair until the downstream multiplier takes it.
module mat_operand_loader #(
  parameter int W = 4
) (
  input  logic           gclk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  output logic           in_ready,
  output logic           mat_valid,
  input  logic           mat_ready,
  output logic [4*W-1:0] mat_a,
  output logic [4*W-1:0] mat_b,
  output logic [2:0]     load_cnt
);

  typedef enum logic {
    LOAD,
    PRESENT
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [4*W-1:0] a_q, a_d;
  logic [4*W-1:0] b_q, b_d;

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // cnt_q[2] selects A or B, cnt_q[1:0] the slot within it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    if (flush) begin
      state_d = LOAD;
      cnt_d   = '0;
      a_d     = '0;
      b_d     = '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (in_valid) begin
            for (int k = 0; k < 4; k++) begin
              if (cnt_q[1:0] == 2'(k)) begin
                if (cnt_q[2]) b_d[k*W +: W] = in_data;
                else          a_d[k*W +: W] = in_data;
              end
            end
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = PRESENT;
          end
        end
        PRESENT: begin
          if (mat_ready) state_d = LOAD;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == LOAD) && !rst;
  assign mat_valid = (state_q == PRESENT);
  assign mat_a     = a_q;
  assign mat_b     = b_q;
  assign load_cnt  = cnt_q;

endmodule

// File: tb/tb_mat_operand_loader.sv
// Directed and randomized bench for mat_operand_loader against
// a slot-array reference model.
module tb_mat_operand_loader;

  localparam int W = 4;

  logic           gclk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_ready;
  logic           mat_valid;
  logic           mat_ready = 1'b0;
  logic [4*W-1:0] mat_a;
  logic [4*W-1:0] mat_b;
  logic [2:0]     load_cnt;

  mat_operand_loader #(.W(W)) dut (
    .gclk      (gclk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mat_valid (mat_valid),
    .mat_ready (mat_ready),
    .mat_a     (mat_a),
    .mat_b     (mat_b),
    .load_cnt  (load_cnt)
  );

  always #5 gclk = ~gclk;

  int passed = 0;
  int total  = 0;

  // reference model: which phase, how many received, and the 8 slots
  bit m_present;
  int m_cnt;
  int m_el[8];

  function automatic logic [4*W-1:0] pack(input int base);
    logic [4*W-1:0] r;
    r = '0;
    for (int k = 0; k < 4; k++)
      r = r | ((4*W)'(m_el[base+k]) << (k*W));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_present = 0;
    m_cnt = 0;
    for (int k = 0; k < 8; k++) m_el[k] = 0;
  endtask

  task automatic model_edge();
    if (flush) begin
      model_reset();
    end else if (!m_present) begin
      if (in_valid) begin
        m_el[m_cnt] = int'(in_data);
        m_cnt++;
        if (m_cnt == 8) begin
          m_cnt = 0;
          m_present = 1;
        end
      end
    end else if (mat_ready) begin
      m_present = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(mat_valid), 64'(m_present));
    chk({tag, ".ready"}, 64'(in_ready), 64'(!m_present && !rst));
    chk({tag, ".cnt"}, 64'(load_cnt), 64'(m_cnt));
    chk({tag, ".a"}, 64'(mat_a), 64'(pack(0)));
    chk({tag, ".b"}, 64'(mat_b), 64'(pack(4)));
  endtask

  // inputs are set by the caller at posedge+1; one edge is applied
  task automatic step(input string tag);
    model_edge();
    @(posedge gclk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    in_valid = 0;
    flush = 0;
    mat_ready = 0;
  endtask

  task automatic load8_rand(input string tag);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1;
      in_data = W'($urandom_range(0, 15));
      step(tag);
    end
    in_valid = 0;
  endtask

  task automatic release_pair(input string tag);
    mat_ready = 1;
    step(tag);
    mat_ready = 0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset_async");
    @(posedge gclk);
    #1;
    check_all("reset_hold");
    rst = 0;
    #1;
    check_all("reset_release");

    // basic load 1..8
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1;
      in_data = W'(i);
      mat_ready = 0;
      step("basic");
    end
    chk("basic.a_const", 64'(mat_a), 64'h4321);
    chk("basic.b_const", 64'(mat_b), 64'h8765);
    chk("basic.valid_const", 64'(mat_valid), 64'd1);
    chk("basic.ready_const", 64'(in_ready), 64'd0);

    // held presentation with input backpressure
    in_valid = 1;
    in_data = 4'hF;
    for (int i = 0; i < 5; i++) step("hold");
    chk("hold.b_const", 64'(mat_b), 64'h8765);
    in_valid = 0;
    release_pair("release");
    chk("release.ready_const", 64'(in_ready), 64'd1);

    // input bubbles
    for (int i = 0; i < 16; i++) begin
      in_valid = (i % 2 == 0);
      in_data = W'($urandom_range(0, 15));
      step("bubble");
    end
    idle();
    chk("bubble.valid_const", 64'(mat_valid), 64'd1);
    release_pair("bubble_rel");

    // mid-load flush
    for (int i = 0; i < 5; i++) begin
      in_valid = 1;
      in_data = W'($urandom_range(0, 8));
      step("preflush");
    end
    in_data = W'(9);
    flush = 1;
    chk("flush.ready_same", 64'(in_ready), 64'd1);
    step("flush");
    flush = 0;
    chk("flush.a_zero", 64'(mat_a), 64'd0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1;
      in_data = W'($urandom_range(0, 8));
      step("postflush");
    end
    idle();
    release_pair("postflush_rel");

    // async reset during presentation
    load8_rand("prerst");
    #2;
    rst = 1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge gclk);
    #1;
    rst = 0;
    in_valid = 1;
    in_data = 4'hA;
    step("after_rst");
    chk("after_rst.a00", 64'(mat_a[W-1:0]), 64'hA);
    idle();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      in_data = W'($urandom_range(0, 15));
      mat_ready = 1'($urandom_range(0, 2) == 0);
      flush = 1'($urandom_range(0, 29) == 0);
      step("rand");
    end
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
